apb_requester: RTL
==================

APB_REQUESTER -- requirements
Module: apb_requester

Interface
REQ-001 SHALL take parameter TIMEOUT_CYCLES, default 16, max ACCESS-phase cycles before abort (used only under the timeout macro).
REQ-002 SHALL take parameter SLV_SHIFT, default 12, LSB position of the slave-index field in addr.
REQ-003 SHALL provide PCLK  input  1  clock; all logic on rising edge; one clock only.
REQ-004 SHALL provide PRESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide transfer  input  1  front request strobe, sampled only in IDLE.
REQ-006 SHALL provide write  input  1  1 = write, 0 = read; captured with transfer.
REQ-007 SHALL provide addr  input  32  byte address; captured with transfer.
REQ-008 SHALL provide wdata  input  DATA_WIDTH  write data; captured with transfer.
REQ-009 SHALL provide rdata  output  DATA_WIDTH  read data; valid while ready=1.
REQ-010 SHALL provide ready  output  1  one-cycle completion pulse.
REQ-011 SHALL provide err  output  1  completion error flag; valid while ready=1.
REQ-012 SHALL provide PADDR  output  ADDR_WIDTH, PSEL  output  NUM_SLAVE, PENABLE  output  1, PWRITE  output  1, PWDATA  output  DATA_WIDTH, PREADY  input  1, PRDATA  input  DATA_WIDTH: APB requester side.

Function
REQ-013 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; all outputs registered.
REQ-014 IDLE: transfer=1 SHALL capture write/addr/wdata and go to SETUP next cycle; transfer=0 stays IDLE.
REQ-015 SETUP: PSEL one-hot at idx=addr[SLV_SHIFT +: $clog2(NUM_SLAVE)], PENABLE=0, PADDR=addr[ADDR_WIDTH-1:0], PWRITE/PWDATA = captured values; always to ACCESS after one cycle.
REQ-016 ACCESS: PENABLE=1, PSEL/PADDR/PWRITE/PWDATA held stable; PREADY=1 -> IDLE, else stay (wait states unbounded unless timeout macro).
REQ-017 On PREADY=1 in ACCESS, next cycle SHALL drive ready=1, err=0, PSEL=0, PENABLE=0; rdata=PRDATA for reads, 0 for writes.
REQ-018 Zero-wait latency: transfer at cycle T -> SETUP T+1, ACCESS T+2, ready T+3; each wait state adds one cycle.
REQ-019 idx >= NUM_SLAVE (decode miss): SHALL skip APB (PSEL stays 0), go SETUP->IDLE, ready=1, err=1, rdata=0 at T+2.
REQ-020 transfer while not in IDLE SHALL be ignored (no queuing); transfer in the same IDLE cycle as ready=1 SHALL be accepted.
REQ-021 PSEL SHALL never have more than one bit set; PENABLE=1 only with PSEL nonzero.

Reset
REQ-022 PRESET=1 SHALL force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, timeout counter=0.
REQ-023 PRESET mid-transfer SHALL abandon it without a ready pulse; same-cycle transfer ignored.

Configuration
REQ-024 Macro APB_REQ_TIMEOUT_EN defined: counter counts ACCESS cycles; reaching TIMEOUT_CYCLES without PREADY -> IDLE, ready=1, err=1, rdata=0, PSEL/PENABLE deasserted.
REQ-025 Macro undefined: no counter logic; err=1 only on decode miss; ACCESS waits indefinitely.

Structure
REQ-026 ADDR_WIDTH, DATA_WIDTH, NUM_SLAVE, and the state enum typedef (IDLE, SETUP, ACCESS) SHALL live in apb_pkg.
REQ-027 Slave-index decode SHALL be sub-module apb_decoder (addr in, one-hot PSEL and miss out, combinational); FSM stays in apb_requester.

Verification
REQ-028 Write addr=0x0000_1004, wdata=0xA5A5_A5A5, PREADY tied 1 -> PSEL=0b0010 at T+1, PENABLE T+2, ready=1 err=0 at T+3.
REQ-029 Read addr=0x0000_0010, PREADY low 3 ACCESS cycles, PRDATA=0x1234_5678 -> ready at T+6, rdata=0x1234_5678.
REQ-030 addr with idx=NUM_SLAVE -> PSEL stays 0, ready=1 err=1 rdata=0 at T+2.
REQ-031 Back-to-back: second transfer in ready cycle -> second SETUP next cycle, ready pulses 3 cycles apart.
REQ-032 PRESET in ACCESS -> next cycle IDLE, PSEL=0, PENABLE=0, no ready pulse.
REQ-033 APB_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> ready=1 err=1 after 4 ACCESS cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared widths, slave count and FSM state encoding for the APB requester.
// Build option: define APB_REQ_TIMEOUT_EN to bound ACCESS-phase wait states.
package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_SLAVE  = 4;

    // One bit wider than $clog2(NUM_SLAVE) so an index of NUM_SLAVE is
    // representable and can be decoded as a miss.
    localparam int SLV_IDX_W = $clog2(NUM_SLAVE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_requester_if.sv
// Front-end request/response port plus APB requester-side bus, bundled.
// master = the requester's view, slave = the environment driving it.
interface apb_requester_if;
    import apb_pkg::*;

    logic                     transfer;
    logic                     write;
    logic [31:0]              addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [DATA_WIDTH-1:0]    rdata;
    logic                     ready;
    logic                     err;

    logic [ADDR_WIDTH-1:0]    PADDR;
    logic [NUM_SLAVE-1:0]     PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [DATA_WIDTH-1:0]    PWDATA;
    logic                     PREADY;
    logic [DATA_WIDTH-1:0]    PRDATA;

    modport master (
        input  transfer, write, addr, wdata, PREADY, PRDATA,
        output rdata, ready, err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output transfer, write, addr, wdata, PREADY, PRDATA,
        input  rdata, ready, err, PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

endinterface

// File: rtl/apb_decoder.sv
// Combinational slave-index decode: one-hot PSEL pattern and a miss flag for
// indices at or beyond NUM_SLAVE.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int SLV_SHIFT = 12
) (
    input  logic [31:0]          addr,
    output logic [NUM_SLAVE-1:0] psel,
    output logic                 miss
);

    logic [SLV_IDX_W-1:0] idx;

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        idx  = addr[SLV_SHIFT +: SLV_IDX_W];
        psel = '0;
        for (int i = 0; i < NUM_SLAVE; i++) begin
            psel[i] = (int'(idx) == i);
        end
        miss = ~|psel;
    end

endmodule

// File: rtl/apb_requester.sv
// Single-outstanding APB requester: IDLE -> SETUP -> ACCESS -> IDLE, all
// outputs registered. Optional ACCESS timeout under APB_REQ_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int SLV_SHIFT      = 12
) (
    input  logic            PCLK,
    input  logic            PRESET,
    apb_requester_if.master bus
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;

    if (TIMEOUT_CYCLES < 1 || SLV_SHIFT < 0 || SLV_SHIFT + SLV_IDX_W > 32) begin : g_bad_cfg
        $error("apb_requester: TIMEOUT_CYCLES or SLV_SHIFT out of range");
    end

    logic [1:0]            state;
    logic [NUM_SLAVE-1:0]  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  miss_q;

    logic [NUM_SLAVE-1:0]  dec_psel;
    logic                  dec_miss;

    // Decode the live request address so PSEL is already valid in SETUP.
    apb_decoder #(.SLV_SHIFT(SLV_SHIFT)) u_decoder (
        .addr (bus.addr),
        .psel (dec_psel),
        .miss (dec_miss)
    );

`ifdef APB_REQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`endif

    // NOTE: state registers use non-blocking assignments; reset is synchronous and high.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= S_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            miss_q    <= 1'b0;
`ifdef APB_REQ_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.transfer) begin
                        state    <= S_SETUP;
                        psel_q   <= dec_psel;
                        miss_q   <= dec_miss;
                        paddr_q  <= bus.addr[ADDR_WIDTH-1:0];
                        pwrite_q <= bus.write;
                        pwdata_q <= bus.wdata;
                    end
                end

                S_SETUP: begin
                    if (miss_q) begin
                        // No slave owns this index: complete with error, no bus cycle.
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        state     <= S_ACCESS;
                        penable_q <= 1'b1;
`ifdef APB_REQ_TIMEOUT_EN
                        to_cnt    <= '0;
`endif
                    end
                end

                S_ACCESS: begin
                    if (bus.PREADY) begin
                        state     <= S_IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
`ifdef APB_REQ_TIMEOUT_EN
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // This was the last permitted ACCESS cycle: abort with error.
                        state     <= S_IDLE;
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        ready_q   <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else begin
                        to_cnt    <= to_cnt + CNT_W'(1);
`endif
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.rdata   = rdata_q;
    assign bus.ready   = ready_q;
    assign bus.err     = err_q;

endmodule
